// File: rtl/ring_osc_pkg.sv
// Shared definitions for the ring-oscillator measurement path: FSM states and
// default parameter values, also used by the oscillator top level.
package ring_osc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int DEF_GATE_CYCLES   = 1200000;
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_CNT_W         = 24;
    localparam int DEF_SYNC_STAGES   = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge
// detector; rise is a single-cycle pulse in the clk domain.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Enables the ring oscillator, waits for it to settle, then counts rising edges
// of its divided output over a fixed clk-timed gate and reports the count.
module ring_osc_freq_meter
    import ring_osc_pkg::*;
#(
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             osc_div_in,
    output logic             osc_enable,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow
);

    localparam int TMR_W = $clog2(max_int(GATE_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             osc_en_q, osc_en_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             rise;
    logic [CNT_W-1:0] cnt_inc;
    logic             sat_hit;

    sync_rise_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (osc_div_in),
        .rise(rise)
    );

    always_comb begin
        // Saturating increment: a rise at full scale marks overflow instead of wrapping
        cnt_inc  = (rise && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
        sat_hit  = rise && (cnt_q == CNT_MAX);

        state_d  = state_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        osc_en_d = osc_en_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    osc_en_d = 1'b1;
                    timer_d  = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    timer_d = GATE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            MEASURE: begin
                cnt_d = cnt_inc;
                ovf_d = ovf_q | sat_hit;
                // Last gate cycle still counts its own rise
                if (timer_q == '0) begin
                    state_d  = DONE;
                    result_d = cnt_inc;
                    valid_d  = 1'b1;
                    osc_en_d = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DONE: begin
                if (valid_q && result_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            osc_en_q <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            osc_en_q <= osc_en_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign osc_enable   = osc_en_q;
    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overflow     = ovf_q;

endmodule
